// File: rtl/cnt_pkg.sv
// Shared definitions for the mod-60 BCD counters (up and down variants).
// q is packed as {tens[2:0], ones[3:0]}.
package cnt_pkg;

  localparam int ONES_W = 4;
  localparam int TENS_W = 3;

  localparam logic [ONES_W-1:0] BCD_ONES_MAX   = 4'd9;
  localparam logic [TENS_W-1:0] BCD_TENS_MAX60 = 3'd5;

  // True when v is a legal mod-60 BCD value (00..59).
  function automatic logic bcdValid60(input logic [TENS_W+ONES_W-1:0] v);
    return (v[ONES_W-1:0] <= BCD_ONES_MAX) &&
           (v[TENS_W+ONES_W-1:ONES_W] <= BCD_TENS_MAX60);
  endfunction

endpackage

// File: rtl/cnt10_down.sv
// Single BCD digit down-counter with load, borrow-in and borrow-out.
// Wraps from 0 to the digit's own maximum so one module serves ones and tens.
module cnt10_down #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  input  logic         bi,
  input  logic [W-1:0] max,
  output logic [W-1:0] q,
  output logic         bo
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] digit_q;
  logic [W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (ld) begin
      digit_d = d;
    end else if (bi) begin
      digit_d = (digit_q == '0) ? max : (digit_q - ONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q <= RST_VAL;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q  = digit_q;
  // The borrow ripples onward only when this digit actually wraps this edge.
  assign bo = bi & (digit_q == '0) & ~ld;

endmodule

// File: rtl/cnt60_down.sv
// Modulo-60 BCD down-counter: two cascaded digit counters plus load
// validation, a one-cycle load-error pulse and a zero flag.
module cnt60_down
  import cnt_pkg::*;
#(
  parameter logic [6:0] RST_VAL = 7'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [6:0] d,
  input  logic       bi,
  output logic       bo,
  output logic [6:0] q,
  output logic       zero,
  output logic       lerr
);

  generate
    if (!bcdValid60(RST_VAL)) begin : g_badRstVal
      $error("cnt60_down: RST_VAL must be BCD 00..59");
    end
  endgenerate

  logic              dValid;
  logic              ldValid;
  logic              countEn;
  logic              onesBo;
  logic [ONES_W-1:0] onesQ;
  logic [TENS_W-1:0] tensQ;
  logic              lerr_q;
  logic              lerr_d;

  assign dValid  = bcdValid60(d);
  assign ldValid = ld & dValid;
  // An invalid load still suppresses counting, so q simply holds.
  assign countEn = bi & ~ld;

  cnt10_down #(
    .W       (ONES_W),
    .RST_VAL (RST_VAL[ONES_W-1:0])
  ) u_ones (
    .clk (clk),
    .rst (rst),
    .ld  (ldValid),
    .d   (d[ONES_W-1:0]),
    .bi  (countEn),
    .max (BCD_ONES_MAX),
    .q   (onesQ),
    .bo  (onesBo)
  );

  cnt10_down #(
    .W       (TENS_W),
    .RST_VAL (RST_VAL[TENS_W+ONES_W-1:ONES_W])
  ) u_tens (
    .clk (clk),
    .rst (rst),
    .ld  (ldValid),
    .d   (d[TENS_W+ONES_W-1:ONES_W]),
    .bi  (onesBo),
    .max (BCD_TENS_MAX60),
    .q   (tensQ),
    .bo  (bo)
  );

  always_comb begin
    lerr_d = ld & ~dValid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lerr_q <= 1'b0;
    end else begin
      lerr_q <= lerr_d;
    end
  end

  assign q    = {tensQ, onesQ};
  assign zero = (q == 7'h00);
  assign lerr = lerr_q;

endmodule

// File: tb/tb_cnt60_down.sv
// Self-checking bench for cnt60_down: directed steps plus random traffic on a
// seconds -> minutes cascade, compared with an integer countdown model.
module tb_cnt60_down;

  logic       clk;
  logic       rst;
  logic       ldS, ldM, biS;
  logic [6:0] dS, dM;
  logic       boS, boM, zeroS, zeroM, lerrS, lerrM;
  logic [6:0] qS, qM;

  int checks   = 0;
  int failures = 0;

  // Reference state kept as plain integers 0..59.
  int secM, minM;
  bit lerrSecM, lerrMinM;

  cnt60_down #(.RST_VAL(7'h00)) u_sec (
    .clk (clk), .rst (rst), .ld (ldS), .d (dS), .bi (biS),
    .bo (boS), .q (qS), .zero (zeroS), .lerr (lerrS)
  );

  cnt60_down #(.RST_VAL(7'h00)) u_min (
    .clk (clk), .rst (rst), .ld (ldM), .d (dM), .bi (boS),
    .bo (boM), .q (qM), .zero (zeroM), .lerr (lerrM)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic bit isValid(input logic [6:0] v);
    return (v[3:0] <= 4'd9) && (v[6:4] <= 3'd5);
  endfunction

  function automatic int toInt(input logic [6:0] v);
    return int'(v[6:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [6:0] toBcd(input int n);
    logic [6:0] r;
    r[6:4] = 3'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".secQ"},    qS,           toBcd(secM));
    checkVal({tag, ".secZero"}, {6'd0, zeroS}, {6'd0, secM == 0});
    checkVal({tag, ".secLerr"}, {6'd0, lerrS}, {6'd0, lerrSecM});
    checkVal({tag, ".minQ"},    qM,           toBcd(minM));
    checkVal({tag, ".minZero"}, {6'd0, zeroM}, {6'd0, minM == 0});
    checkVal({tag, ".minLerr"}, {6'd0, lerrM}, {6'd0, lerrMinM});
  endtask

  // Drive one cycle of inputs, check borrow-outs before the edge, advance the
  // model across the edge, then check registered outputs on the falling edge.
  task automatic applyStimulus(input string tag, input logic l, input logic [6:0] dv,
                               input logic b, input logic lm, input logic [6:0] dmv);
    bit secBo, minBo;
    ldS = l; dS = dv; biS = b; ldM = lm; dM = dmv;
    #1;
    secBo = b && (secM == 0) && !l;
    minBo = secBo && (minM == 0) && !lm;
    checkVal({tag, ".secBo"}, {6'd0, boS}, {6'd0, secBo});
    checkVal({tag, ".minBo"}, {6'd0, boM}, {6'd0, minBo});
    @(posedge clk);
    lerrSecM = l && !isValid(dv);
    if (l) begin
      if (isValid(dv)) secM = toInt(dv);
    end else if (b) begin
      secM = (secM + 59) % 60;
    end
    lerrMinM = lm && !isValid(dmv);
    if (lm) begin
      if (isValid(dmv)) minM = toInt(dmv);
    end else if (secBo) begin
      minM = (minM + 59) % 60;
    end
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    $display("[TB] cnt60_down bench starting");
    rst = 1'b1; ldS = 1'b0; dS = 7'h00; biS = 1'b1; ldM = 1'b0; dM = 7'h00;
    secM = 0; minM = 0; lerrSecM = 1'b0; lerrMinM = 1'b0;

    #5 rst = 1'b0;
    #1;
    checkVal("rst.secQ",    qS,            7'h00);
    checkVal("rst.secZero", {6'd0, zeroS}, 7'h01);
    checkVal("rst.secBo",   {6'd0, boS},   7'h01);
    checkVal("rst.secLerr", {6'd0, lerrS}, 7'h00);
    checkVal("rst.minQ",    qM,            7'h00);

    @(negedge clk);
    rst = 1'b1;
    applyStimulus("rstRelease", 1'b0, 7'h00, 1'b1, 1'b0, 7'h00);
    checkVal("rstRelease.const", qS, 7'h59);

    applyStimulus("load59", 1'b1, 7'h59, 1'b1, 1'b1, 7'h05);
    for (int i = 0; i < 60; i++) begin
      applyStimulus("countdown", 1'b0, 7'h00, 1'b1, 1'b0, 7'h00);
    end
    checkVal("countdown.wrapConst", qS, 7'h59);

    applyStimulus("load42", 1'b1, 7'h42, 1'b0, 1'b0, 7'h00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("gateHold", 1'b0, 7'h00, 1'b0, 1'b0, 7'h00);
    end
    applyStimulus("gateResume", 1'b0, 7'h00, 1'b1, 1'b0, 7'h00);
    checkVal("gateResume.const", qS, 7'h41);

    applyStimulus("load30", 1'b1, 7'h30, 1'b0, 1'b0, 7'h00);
    applyStimulus("borrow30", 1'b0, 7'h00, 1'b1, 1'b0, 7'h00);
    checkVal("borrow30.const", qS, 7'h29);
    applyStimulus("load10", 1'b1, 7'h10, 1'b0, 1'b0, 7'h00);
    applyStimulus("borrow10", 1'b0, 7'h00, 1'b1, 1'b0, 7'h00);
    checkVal("borrow10.const", qS, 7'h09);
    applyStimulus("load01", 1'b1, 7'h01, 1'b0, 1'b0, 7'h00);
    applyStimulus("borrow01", 1'b0, 7'h00, 1'b1, 1'b0, 7'h00);
    checkVal("borrow01.const", qS, 7'h00);

    applyStimulus("ldPriority", 1'b1, 7'h25, 1'b1, 1'b0, 7'h00);
    checkVal("ldPriority.const", qS, 7'h25);
    applyStimulus("ldBad3A", 1'b1, 7'h3A, 1'b1, 1'b0, 7'h00);
    checkVal("ldBad3A.lerr", {6'd0, lerrS}, 7'h01);
    applyStimulus("lerrClear", 1'b0, 7'h00, 1'b0, 1'b0, 7'h00);
    applyStimulus("ldBad60", 1'b1, 7'h60, 1'b0, 1'b1, 7'h7F);
    checkVal("ldBad60.hold", qS, 7'h25);
    applyStimulus("lerrClear2", 1'b0, 7'h00, 1'b0, 1'b0, 7'h00);

    applyStimulus("cascLoad0100", 1'b1, 7'h00, 1'b0, 1'b1, 7'h01);
    applyStimulus("cascStep", 1'b0, 7'h00, 1'b1, 1'b0, 7'h00);
    checkVal("cascStep.sec", qS, 7'h59);
    checkVal("cascStep.min", qM, 7'h00);
    applyStimulus("cascLoad0000", 1'b1, 7'h00, 1'b0, 1'b1, 7'h00);
    applyStimulus("cascWrap", 1'b0, 7'h00, 1'b1, 1'b0, 7'h00);
    checkVal("cascWrap.sec", qS, 7'h59);
    checkVal("cascWrap.min", qM, 7'h59);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("random",
                    ($urandom_range(0, 7) == 0), 7'($urandom_range(0, 127)),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0), 7'($urandom_range(0, 127)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
